// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: accepts pattern commands over valid/ready and drives an
// active-low LED register in static, rotate, bounce or blink mode.
module led_seq_ctrl #(
    parameter int unsigned LED_W = 8,
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [LED_W-1:0] cmd_arg_i,
    input  logic [DIV_W-1:0] cmd_div_i,
    output logic [LED_W-1:0] led_o,
    output logic             tick_o,
    output logic [2:0]       state_o
);

    localparam int unsigned PosW = $clog2(LED_W);
    localparam logic [LED_W-1:0] LedOne = LED_W'(1);
    localparam logic [PosW-1:0] PosMax = PosW'(LED_W - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StRotate = 3'd2,
        StBounce = 3'd3,
        StBlink  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OpStatic = 2'd0,
        OpRotate = 2'd1,
        OpBounce = 2'd2,
        OpBlink  = 2'd3
    } op_e;

    state_e           state_q;
    op_e              op_q;
    logic [LED_W-1:0] arg_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [PosW-1:0]  pos_q;
    logic             dir_q;   // 0 = moving up, 1 = moving down
    logic             phase_q;
    logic [LED_W-1:0] led_q;
    logic             ready_q;

    logic             active;
    logic             tick;
    logic             accept;
    logic [PosW-1:0]  pos_step;
    logic [LED_W-1:0] step_led;
    logic [LED_W-1:0] load_led;

    // Prescaler tick, handshake and the LED value one pattern step ahead.
    always_comb begin
        active   = (state_q == StRotate) || (state_q == StBounce) || (state_q == StBlink);
        tick     = active && (cnt_q == div_q);
        accept   = cmd_valid_i && ready_q;
        pos_step = dir_q ? (pos_q - PosW'(1)) : (pos_q + PosW'(1));
        step_led = led_q;
        case (state_q)
            StRotate: step_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
            StBounce: step_led = ~(LedOne << pos_step);
            // Next phase is ~phase_q: odd phases are dark.
            StBlink:  step_led = phase_q ? arg_q : '1;
            default:  step_led = led_q;
        endcase
        load_led = (op_q == OpBounce) ? ~LedOne : arg_q;
    end

    // Mode FSM with prescaler, pattern state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OpStatic;
            arg_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            phase_q <= 1'b0;
            led_q   <= '1;
            ready_q <= 1'b1;
        end else if (state_q == StLoad) begin
            cnt_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            phase_q <= 1'b0;
            led_q   <= load_led;
            ready_q <= 1'b1;
            case (op_q)
                OpRotate: state_q <= StRotate;
                OpBounce: state_q <= StBounce;
                OpBlink:  state_q <= StBlink;
                default:  state_q <= StIdle;
            endcase
        end else begin
            // A tick on the accept edge still lands on led; LOAD overwrites it.
            if (tick) begin
                cnt_q <= '0;
                led_q <= step_led;
                if (state_q == StBounce) begin
                    pos_q <= pos_step;
                    if (pos_step == PosMax) begin
                        dir_q <= 1'b1;
                    end else if (pos_step == '0) begin
                        dir_q <= 1'b0;
                    end
                end
                if (state_q == StBlink) begin
                    phase_q <= ~phase_q;
                end
            end else if (active) begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
            if (accept) begin
                op_q    <= op_e'(cmd_op_i);
                arg_q   <= cmd_arg_i;
                div_q   <= cmd_div_i;
                state_q <= StLoad;
                ready_q <= 1'b0;
            end
        end
    end

    assign cmd_ready_o = ready_q;
    assign led_o       = led_q;
    assign tick_o      = tick;
    assign state_o     = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed scenarios plus random commands checked
// against a closed-form model of the LED pattern after s steps.
module tb_led_seq_ctrl;

    localparam int LED_W = 8;
    localparam int DIV_W = 24;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LED_W-1:0] cmd_arg;
    logic [DIV_W-1:0] cmd_div;
    logic [LED_W-1:0] led;
    logic             tick;
    logic [2:0]       state;

    int n_pass = 0;
    int n_fail = 0;

    led_seq_ctrl #(.LED_W(LED_W), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_op_i   (cmd_op),
        .cmd_arg_i  (cmd_arg),
        .cmd_div_i  (cmd_div),
        .led_o      (led),
        .tick_o     (tick),
        .state_o    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout, wanted finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h wanted %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // LED pattern after s completed steps, from the mode rules directly.
    function automatic logic [7:0] exp_led(input logic [1:0] op, input logic [7:0] arg,
                                           input int s);
        logic [15:0] x;
        int p;
        int pos;
        case (op)
            2'd1: begin
                x = {arg, arg} << (s % LED_W);
                return x[15:8];
            end
            2'd2: begin
                p   = s % (2 * (LED_W - 1));
                pos = (p < LED_W) ? p : 2 * (LED_W - 1) - p;
                return ~(8'd1 << pos);
            end
            2'd3:    return (s % 2 == 1) ? 8'hFF : arg;
            default: return arg;
        endcase
    endfunction

    function automatic logic [2:0] exp_state(input logic [1:0] op);
        case (op)
            2'd1:    return 3'd2;
            2'd2:    return 3'd3;
            2'd3:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Issue one command, then check ncyc samples starting right after LOAD.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg, input int div,
                           input int ncyc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_div   = DIV_W'(div);
        step();
        check("accept_state", 32'(state), 32'd1);
        check("accept_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_arg   = 8'($urandom);
        cmd_div   = DIV_W'($urandom);
        step();
        for (int n = 0; n < ncyc; n++) begin
            check("led", 32'(led), 32'(exp_led(op, arg, n / (div + 1))));
            check("state", 32'(state), 32'(exp_state(op)));
            check("tick", 32'(tick), 32'((op != 2'd0) && ((n % (div + 1)) == div)));
            check("ready", 32'(cmd_ready), 32'd1);
            if (n < ncyc - 1) step();
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_arg   = '0;
        cmd_div   = '0;
        repeat (3) step();
        check("rst_led", 32'(led), 32'hFF);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_led", 32'(led), 32'hFF);
            check("idle_state", 32'(state), 32'd0);
            check("idle_ready", 32'(cmd_ready), 32'd1);
            check("idle_tick", 32'(tick), 32'd0);
        end

        // Rotate, bounce, blink, static.
        run_cmd(2'd1, 8'hFE, 3, 36);
        run_cmd(2'd2, 8'h00, 0, 30);
        run_cmd(2'd3, 8'h0F, 1, 12);
        run_cmd(2'd0, 8'hAA, 0, 10);

        // Back-to-back commands with cmd_valid held high.
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_arg   = 8'h3C;
        cmd_div   = DIV_W'(2);
        step();
        check("b2b_acc1_state", 32'(state), 32'd1);
        check("b2b_acc1_ready", 32'(cmd_ready), 32'd0);
        cmd_op  = 2'd3;
        cmd_arg = 8'h55;
        cmd_div = DIV_W'(0);
        step();
        check("b2b_load1_led", 32'(led), 32'h3C);
        check("b2b_load1_state", 32'(state), 32'd2);
        check("b2b_load1_ready", 32'(cmd_ready), 32'd1);
        step();
        check("b2b_acc2_state", 32'(state), 32'd1);
        check("b2b_acc2_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        step();
        check("b2b_load2_led", 32'(led), 32'h55);
        check("b2b_load2_state", 32'(state), 32'd4);
        step();
        check("b2b_blink_led", 32'(led), 32'hFF);

        // Asynchronous reset mid-rotate at led=F7.
        run_cmd(2'd1, 8'hFE, 3, 13);
        check("pre_rst_led", 32'(led), 32'hF7);
        #2;
        rst = 1'b1;
        #1;
        check("arst_led", 32'(led), 32'hFF);
        check("arst_state", 32'(state), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        check("arst_tick", 32'(tick), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_led", 32'(led), 32'hFF);
        run_cmd(2'd1, 8'h7E, 1, 20);

        // Random commands, each preempting the previous mode.
        for (int k = 0; k < 40; k++) begin
            run_cmd(2'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
                    int'($urandom_range(1, 40)));
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
